// File: rtl/n64_frame_rx.sv
// n64_frame_rx: N64 controller response receiver.
// The N64 data line is sampled on clk_i and each low pulse is classified by
// its width in clock cycles. DATA_BITS data bits plus a stop bit make a frame.
// Optional input glitch filter: define N64_RX_GLITCH_FILTER_EN.
module n64_frame_rx #(
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned THRESH_CYC  = 28,
    parameter int unsigned MAX_LOW_CYC = 70,
    parameter int unsigned IDLE_CYC    = 84,
    parameter int unsigned GLITCH_CYC  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 N64_in,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_TOP = ((MAX_LOW_CYC > IDLE_CYC) ? MAX_LOW_CYC : IDLE_CYC) + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MAXLOW_C = CNT_W'(MAX_LOW_CYC);
    localparam logic [CNT_W-1:0] IDLE_C   = CNT_W'(IDLE_CYC);
    localparam logic [BIT_W-1:0] NBITS_C  = BIT_W'(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic [1:0]           vld_q;
    logic                 line;
    logic                 line_prev_q;
    logic                 armed_q;
    logic                 fall;
    logic                 rise;

    state_t               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [BIT_W-1:0]     bitcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 bit_d;

    // Two-flop synchroniser; vld_q marks when the flops hold real line samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld_q   <= '0;
        end else begin
            sync1_q <= N64_in;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    localparam int unsigned GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);

    logic          filt_q;
    logic [GW-1:0] gcnt_q;

    // Follow the synchronised line only after it has disagreed for GLITCH_CYC cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            gcnt_q <= '0;
        end else if (sync2_q != filt_q) begin
            if (gcnt_q == GLITCH_LAST) begin
                filt_q <= sync2_q;
                gcnt_q <= '0;
            end else begin
                gcnt_q <= gcnt_q + GW'(1);
            end
        end else begin
            gcnt_q <= '0;
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    // Edge history; armed_q stays low until a genuine high has been seen after
    // reset, so a line already low at release cannot fake a falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_prev_q <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            line_prev_q <= line;
            if (vld_q[1] && sync2_q && line) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall    = armed_q & line_prev_q & ~line;
    assign rise    = ~line_prev_q & line;
    assign count_d = (count_q == CNT_SAT) ? count_q : count_q + CNT_W'(1);
    assign bit_d   = (count_q < THRESH_C);

    // Frame FSM: pulse-width decode, shift-in, frame delivery and fault handling.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (fall) begin
                        state_q  <= ST_LOW;
                        count_q  <= CNT_W'(1);
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!line) begin
                        if (count_q >= MAXLOW_C) begin
                            err_q   <= 1'b1;
                            state_q <= ST_HOLD;
                            count_q <= '0;
                            shift_q <= '0;
                        end else begin
                            count_q <= count_d;
                        end
                    end else if (rise) begin
                        if (bitcnt_q == NBITS_C) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            count_q <= '0;
                        end else begin
                            shift_q  <= (shift_q << 1) | DATA_BITS'(bit_d);
                            bitcnt_q <= bitcnt_q + BIT_W'(1);
                            count_q  <= CNT_W'(1);
                            state_q  <= ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        count_q <= CNT_W'(1);
                        state_q <= ST_LOW;
                    end else if (count_d >= IDLE_C) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else begin
                        count_q <= count_d;
                    end
                end
                ST_HOLD: begin
                    if (!line) begin
                        count_q <= '0;
                    end else if (count_d >= IDLE_C) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else begin
                        count_q <= count_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_n64_frame_rx.sv
// Self-checking bench for n64_frame_rx with a frame scoreboard.
// Build with N64_RX_GLITCH_FILTER_EN to exercise the input glitch filter.
module tb_n64_frame_rx;

    localparam int DATA_BITS = 32;
    localparam int IDLE_CYC  = 84;
`ifdef N64_RX_GLITCH_FILTER_EN
    localparam int LAT = 3 + 3;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        N64_in;
    logic [31:0] data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        busy_o;

    n64_frame_rx #(
        .DATA_BITS  (DATA_BITS),
        .THRESH_CYC (28),
        .MAX_LOW_CYC(70),
        .IDLE_CYC   (IDLE_CYC),
        .GLITCH_CYC (3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .N64_in     (N64_in),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc_q[$];
    int          err_cnt = 0;
    int          err_cyc = 0;
    int          both_cnt = 0;
    int          long_cnt = 0;
    int          bad_change = 0;
    int          busy_seen = 0;
    int          last_rise = 0;
    logic        prev_valid = 1'b0;
    logic        prev_err = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] last_good = '0;

    // One clock, sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_o === 1'b1) begin
            obs_q.push_back(data_o);
            obs_cyc_q.push_back(cyc);
        end
        if (frame_err_o === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (valid_o === 1'b1 && frame_err_o === 1'b1) both_cnt++;
        if ((valid_o === 1'b1 && prev_valid) || (frame_err_o === 1'b1 && prev_err)) long_cnt++;
        if (data_o !== prev_data && valid_o !== 1'b1 && !rst_i) bad_change++;
        if (busy_o === 1'b1) busy_seen++;
        prev_valid = (valid_o === 1'b1);
        prev_err   = (frame_err_o === 1'b1);
        prev_data  = data_o;
    endtask

    task automatic drive(input logic v, input int n);
        if (v && !N64_in) last_rise = cyc;
        N64_in = v;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        if (b) begin drive(1'b0, 14); drive(1'b1, 42); end
        else   begin drive(1'b0, 42); drive(1'b1, 14); end
    endtask

    task automatic send_bit_spiky(input logic b);
        if (b) begin drive(1'b0, 14); drive(1'b1, 20); drive(1'b0, 2); drive(1'b1, 20); end
        else   begin drive(1'b0, 42); drive(1'b1, 6);  drive(1'b0, 2); drive(1'b1, 6);  end
    endtask

    task automatic send_frame(input logic [31:0] d);
        for (int i = DATA_BITS - 1; i >= 0; i--) send_bit(d[i]);
        drive(1'b0, 14);
        drive(1'b1, 20);
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        N64_in = 1'b1;
        repeat (4) tick();
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        rst_i = 1'b0;
        drive(1'b1, 200);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL idle_valid got %0d pulses want 0", obs_q.size()); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL idle_err got %0d pulses want 0", err_cnt); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_seen); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL idle_data got %h want 00000000", data_o); end
    endtask

    task automatic test_frame();
        logic [31:0] exp;
        int e0;
        e0 = err_cnt;
        exp_q.push_back(32'hA5C3_0F81);
        send_frame(32'hA5C3_0F81);
        exp = exp_q.pop_front();
        last_good = exp;
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL frame_count got %0d valid pulses want 1", obs_q.size());
            obs_q.delete(); obs_cyc_q.delete();
        end else begin
            logic [31:0] got; int gc;
            got = obs_q.pop_front(); gc = obs_cyc_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL frame_data got %h want %h", got, exp); end
            checks++; if (gc !== last_rise + LAT) begin errors++; $display("FAIL frame_latency got cycle %0d want %0d", gc, last_rise + LAT); end
        end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL frame_err got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_threshold();
        logic [31:0] base;
        logic [31:0] exp;
        int e0;
        base = 32'h1234_5678;
        e0 = err_cnt;
        exp_q.push_back(32'h9234_5678);
        drive(1'b0, 27); drive(1'b1, 42);
        drive(1'b0, 28); drive(1'b1, 14);
        drive(1'b0, 70); drive(1'b1, 14);
        for (int i = 28; i >= 0; i--) send_bit(base[i]);
        drive(1'b0, 14);
        drive(1'b1, 20);
        exp = exp_q.pop_front();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL thresh_count got %0d valid pulses want 1", obs_q.size());
            obs_q.delete(); obs_cyc_q.delete();
        end else begin
            logic [31:0] got;
            got = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++; if (got !== exp) begin errors++; $display("FAIL thresh_data got %h want %h", got, exp); end
        end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL thresh_err got %0d pulses want 0", err_cnt - e0); end

        e0 = err_cnt;
        drive(1'b0, 71);
        drive(1'b1, IDLE_CYC);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL overlong_err got %0d pulses want 1", err_cnt - e0); end
        exp_q.push_back(32'h0000_0001);
        send_frame(32'h0000_0001);
        exp = exp_q.pop_front();
        last_good = exp;
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL recover_count got %0d valid pulses want 1", obs_q.size());
            obs_q.delete(); obs_cyc_q.delete();
        end else begin
            logic [31:0] got;
            got = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++; if (got !== exp) begin errors++; $display("FAIL recover_data got %h want %h", got, exp); end
        end
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL recover_err got %0d pulses want 1", err_cnt - e0); end
    endtask

    task automatic test_truncated();
        logic [9:0] bits;
        int e0;
        bits = 10'h2B5;
        e0 = err_cnt;
        for (int i = 9; i >= 0; i--) send_bit(bits[i]);
        drive(1'b1, 100);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL trunc_err got %0d pulses want 1", err_cnt - e0); end
        checks++; if (err_cyc !== last_rise + LAT + IDLE_CYC - 1) begin errors++; $display("FAIL trunc_err_time got cycle %0d want %0d", err_cyc, last_rise + LAT + IDLE_CYC - 1); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL trunc_valid got %0d pulses want 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
        checks++; if (data_o !== last_good) begin errors++; $display("FAIL trunc_data got %h want %h", data_o, last_good); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL trunc_busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] exp;
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        drive(1'b0, 5);
        rst_i = 1'b1;
        #1;
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 00000000", data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        checks++; if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin errors++; $display("FAIL midrst_pulses got valid=%b err=%b want 0 0", valid_o, frame_err_o); end
        drive(1'b1, 5);
        rst_i = 1'b0;
        drive(1'b1, 20);
        checks++; if (busy_o !== 1'b0 || data_o !== 32'h0) begin errors++; $display("FAIL postrst_idle got busy=%b data=%h want 0 00000000", busy_o, data_o); end
        exp_q.push_back(32'hFFFF_FFFF);
        send_frame(32'hFFFF_FFFF);
        exp = exp_q.pop_front();
        last_good = exp;
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL postrst_count got %0d valid pulses want 1", obs_q.size());
            obs_q.delete(); obs_cyc_q.delete();
        end else begin
            logic [31:0] got;
            got = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++; if (got !== exp) begin errors++; $display("FAIL postrst_data got %h want %h", got, exp); end
        end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL postrst_err got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        logic [31:0] pat;
        int e0;
        pat = 32'h1234_5678;
        e0 = err_cnt;
        obs_q.delete(); obs_cyc_q.delete();
`ifdef N64_RX_GLITCH_FILTER_EN
        exp_q.push_back(pat);
`endif
        for (int i = DATA_BITS - 1; i >= 0; i--) send_bit_spiky(pat[i]);
        drive(1'b0, 14);
        drive(1'b1, 120);
`ifdef N64_RX_GLITCH_FILTER_EN
        begin
            logic [31:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_q.size() !== 1) begin
                errors++; $display("FAIL glitch_count got %0d valid pulses want 1", obs_q.size());
            end else begin
                checks++; if (obs_q[0] !== exp) begin errors++; $display("FAIL glitch_data got %h want %h", obs_q[0], exp); end
            end
            checks++; if (err_cnt !== e0) begin errors++; $display("FAIL glitch_err got %0d pulses want 0", err_cnt - e0); end
        end
`else
        checks++;
        if (err_cnt == e0 && obs_q.size() == 1 && obs_q[0] === pat) begin
            errors++; $display("FAIL glitch_unfiltered got clean frame %h want error or wrong data", obs_q[0]);
        end
`endif
        obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_protocol();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_err_overlap got %0d cycles want 0", both_cnt); end
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width got %0d long pulses want 0", long_cnt); end
        checks++; if (bad_change !== 0) begin errors++; $display("FAIL data_stable got %0d changes without valid want 0", bad_change); end
    endtask

    initial begin
        rst_i  = 1'b1;
        N64_in = 1'b1;
        test_reset();
        test_frame();
        test_threshold();
        test_truncated();
        test_reset_midframe();
        test_glitch();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
